inst_mem_ctrl: RTL and testbench

- Parametrised instruction-memory controller for the core fetch path. Replaces the fixed 32x512 read-only instruction RAM wrapper.
- Contains a 1-write/1-read synchronous array with configurable width and depth.
- Fetch side: valid/ready request and response handshakes, a response skid/hold register and a flush input.
- Load side: byte-masked write port used by the boot/debug loader to program instructions.

---
 rtl/inst_mem_pkg.sv | 18 +
 rtl/inst_mem_array.sv | 49 ++++
 rtl/inst_mem_ctrl.sv | 136 +++++++++++++
 tb/tb_inst_mem_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_pkg.sv
// inst_mem_pkg: shared types, default sizes and parity helper for the
// instruction-memory controller (optional parity: INST_MEM_PARITY_EN).
package inst_mem_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic logic byte_par(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/inst_mem_array.sv
// inst_mem_array: 1W1R synchronous array, byte-masked write, registered read.
// With INST_MEM_PARITY_EN each byte carries its parity bit above DATA_W.
module inst_mem_array
    import inst_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int MASK_W = DATA_W / 8,
    parameter int WORD_W = DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [MASK_W-1:0] wmask,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];

    // byte-masked write; a byte's parity bit is written with the byte
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (wmask[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
`ifdef INST_MEM_PARITY_EN
                    mem[waddr][DATA_W+i] <= wdata[DATA_W+i];
`endif
                end
            end
        end
    end

    // read register only loads on a read, so it holds the last word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/inst_mem_ctrl.sv
// inst_mem_ctrl: fetch-side instruction memory with response hold and flush.
// Define INST_MEM_PARITY_EN to store and check per-byte even parity.
module inst_mem_ctrl
    import inst_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int MASK_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_instr,
    input  logic              rsp_ready,
    output logic              rsp_perr,
    input  logic              flush,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [MASK_W-1:0] ld_wmask,
    output logic              ld_ready
);

`ifdef INST_MEM_PARITY_EN
    localparam int WORD_W = DATA_W + MASK_W;
`else
    localparam int WORD_W = DATA_W;
`endif

    state_t            state_q;
    state_t            state_d;
    logic              hold_en;
    logic              ld_rdy_q;
    logic              re;
    logic              we;
    logic [WORD_W-1:0] wword;
    logic [WORD_W-1:0] rdata;
    logic [WORD_W-1:0] hold_q;
    logic [WORD_W-1:0] sel;

    assign req_ready = rst_n & ~ld_valid
                     & ((state_q == IDLE) | rsp_ready | flush);
    assign re        = req_valid & req_ready;
    assign we        = ld_valid & ld_rdy_q & rst_n;
    assign ld_ready  = ld_rdy_q;

    assign sel       = (state_q == HOLD) ? hold_q : rdata;
    assign rsp_valid = (state_q != IDLE);
    assign rsp_instr = sel[DATA_W-1:0];

`ifdef INST_MEM_PARITY_EN
    logic [MASK_W-1:0] wpar;
    logic [MASK_W-1:0] mism;

    // parity generation on write, per-byte compare on the response word
    always_comb begin
        wpar = '0;
        mism = '0;
        for (int i = 0; i < MASK_W; i++) begin
            wpar[i] = byte_par(ld_data[8*i +: 8]);
            mism[i] = byte_par(sel[8*i +: 8]) ^ sel[DATA_W+i];
        end
    end

    assign wword    = {wpar, ld_data};
    assign rsp_perr = rsp_valid & (|mism);
`else
    assign wword    = ld_data;
    assign rsp_perr = 1'b0;
`endif

    inst_mem_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .MASK_W(MASK_W),
        .WORD_W(WORD_W)
    ) u_array (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (we),
        .waddr(ld_addr),
        .wdata(wword),
        .wmask(ld_wmask),
        .re   (re),
        .raddr(req_addr),
        .rdata(rdata)
    );

    // state, loader-ready and hold register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ld_rdy_q <= 1'b0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            ld_rdy_q <= 1'b1;
            if (hold_en) begin
                hold_q <= rdata;
            end
        end
    end

    // next state; flush drops the current response like a consume
    always_comb begin
        state_d = state_q;
        hold_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (re) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (flush || rsp_ready) begin
                    state_d = re ? PEND : IDLE;
                end else begin
                    state_d = HOLD;
                    hold_en = 1'b1;
                end
            end
            HOLD: begin
                if (flush || rsp_ready) begin
                    state_d = re ? PEND : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// tb_inst_mem_ctrl: directed plan plus random traffic against a
// one-slot response model and a word/parity memory model.
module tb_inst_mem_ctrl;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic [AW-1:0] req_addr;
    logic          req_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_instr;
    logic          rsp_ready;
    logic          rsp_perr;
    logic          flush;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic [MW-1:0] ld_wmask;
    logic          ld_ready;

    int total;
    int bad;
    bit chk_en;

    logic [DW-1:0] m_mem [512];
    logic [MW-1:0] m_par [512];
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [MW-1:0] m_dpar;
    logic          m_ldrdy;

    inst_mem_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_addr (req_addr),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_instr(rsp_instr),
        .rsp_ready(rsp_ready),
        .rsp_perr (rsp_perr),
        .flush    (flush),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .ld_wmask (ld_wmask),
        .ld_ready (ld_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic mism(input logic [31:0] d,
                                  input logic [3:0] p);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i] = (^d[8*i +: 8]) ^ p[i];
        end
        return |r;
    endfunction

    task automatic check(input logic rr);
        logic ep;
`ifdef INST_MEM_PARITY_EN
        ep = m_valid & mism(m_data, m_dpar);
`else
        ep = 1'b0;
`endif
        chk("req_ready", {31'd0, req_ready}, {31'd0, rr});
        chk("ld_ready", {31'd0, ld_ready}, {31'd0, m_ldrdy});
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
        chk("rsp_instr", rsp_instr, m_data);
        chk("rsp_perr", {31'd0, rsp_perr}, {31'd0, ep});
    endtask

    task automatic update(input logic rr);
        if (!rst_n) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_dpar  = '0;
            m_ldrdy = 1'b0;
        end else begin
            if (req_valid && rr) begin
                m_valid = 1'b1;
                m_data  = m_mem[req_addr];
                m_dpar  = m_par[req_addr];
            end else if (flush || rsp_ready) begin
                m_valid = 1'b0;
            end
            if (ld_valid && m_ldrdy) begin
                for (int i = 0; i < 4; i++) begin
                    if (ld_wmask[i]) begin
                        m_mem[ld_addr][8*i +: 8] = ld_data[8*i +: 8];
                        m_par[ld_addr][i] = ^ld_data[8*i +: 8];
                    end
                end
            end
            m_ldrdy = 1'b1;
        end
    endtask

    task automatic cyc();
        logic rr;
        #1;
        rr = rst_n & ~ld_valid & (~m_valid | rsp_ready | flush);
        if (chk_en) check(rr);
        @(posedge clk);
        update(rr);
        @(negedge clk);
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b1;
        flush     = 1'b0;
        ld_valid  = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        ld_wmask  = '0;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [MW-1:0] m);
        idle();
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        ld_wmask = m;
        cyc();
        idle();
    endtask

    task automatic fetch(input logic [AW-1:0] a, input logic rr);
        idle();
        req_valid = 1'b1;
        req_addr  = a;
        rsp_ready = rr;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        chk_en  = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_dpar  = '0;
        m_ldrdy = 1'b0;
        rst_n   = 1'b0;
        idle();
        cyc();
        chk_en = 1'b1;
        chk("pin_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("pin_rst_instr", rsp_instr, 32'd0);
        chk("pin_rst_ldrdy", {31'd0, ld_ready}, 32'd0);
        chk("pin_rst_reqrdy", {31'd0, req_ready}, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("pin_ldrdy_up", {31'd0, ld_ready}, 32'd1);

        for (int a = 0; a < 512; a++) begin
            load(AW'(a), $urandom, 4'hF);
        end
        load(9'd0, 32'h0000_0013, 4'hF);
        load(9'd5, 32'hDEAD_BEEF, 4'hF);

        fetch(9'd0, 1'b1);
        cyc();
        fetch(9'd5, 1'b1);
        #1;
        chk("pin_b2b_rdy", {31'd0, req_ready}, 32'd1);
        chk("pin_b2b_first", rsp_instr, 32'h0000_0013);
        cyc();
        chk("pin_b2b_second", rsp_instr, 32'hDEAD_BEEF);
        chk("pin_b2b_valid", {31'd0, rsp_valid}, 32'd1);
        idle();
        cyc();

        fetch(9'd5, 1'b0);
        cyc();
        for (int k = 0; k < 3; k++) begin
            fetch(9'd0, 1'b0);
            #1;
            chk("pin_bp_instr", rsp_instr, 32'hDEAD_BEEF);
            chk("pin_bp_rdy", {31'd0, req_ready}, 32'd0);
            cyc();
        end
        fetch(9'd0, 1'b1);
        cyc();
        chk("pin_bp_next", rsp_instr, 32'h0000_0013);
        idle();
        cyc();

        idle();
        ld_valid  = 1'b1;
        ld_addr   = 9'd5;
        ld_data   = 32'h0000_00AA;
        ld_wmask  = 4'b0001;
        req_valid = 1'b1;
        #1;
        chk("pin_prio_rdy", {31'd0, req_ready}, 32'd0);
        cyc();
        fetch(9'd5, 1'b1);
        cyc();
        chk("pin_partial", rsp_instr, 32'hDEAD_BEAA);
        idle();
        cyc();

        fetch(9'd0, 1'b0);
        cyc();
        fetch(9'd5, 1'b0);
        flush = 1'b1;
        #1;
        chk("pin_flush_rdy", {31'd0, req_ready}, 32'd1);
        cyc();
        chk("pin_flush_data", rsp_instr, 32'hDEAD_BEAA);
        idle();
        cyc();

        fetch(9'd5, 1'b0);
        cyc();
        idle();
        rsp_ready = 1'b0;
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("pin_rh_valid", {31'd0, rsp_valid}, 32'd0);
        chk("pin_rh_instr", rsp_instr, 32'd0);
        chk("pin_rh_ldrdy", {31'd0, ld_ready}, 32'd0);
        cyc();
        chk("pin_rh_ldrdy1", {31'd0, ld_ready}, 32'd1);
        fetch(9'd5, 1'b1);
        cyc();
        chk("pin_rh_keep", rsp_instr, 32'hDEAD_BEAA);
        idle();
        cyc();

`ifdef INST_MEM_PARITY_EN
        dut.u_array.mem[5][9] <= ~dut.u_array.mem[5][9];
        m_mem[5][9] = ~m_mem[5][9];
        #1;
        fetch(9'd5, 1'b1);
        cyc();
        chk("pin_perr_bad", {31'd0, rsp_perr}, 32'd1);
        fetch(9'd0, 1'b1);
        cyc();
        chk("pin_perr_ok", {31'd0, rsp_perr}, 32'd0);
`else
        fetch(9'd5, 1'b1);
        cyc();
        chk("pin_perr_off", {31'd0, rsp_perr}, 32'd0);
`endif
        idle();
        cyc();

        for (int k = 0; k < 4000; k++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr  = AW'($urandom);
            rsp_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            ld_valid  = ($urandom_range(0, 6) == 0);
            ld_addr   = AW'($urandom);
            ld_data   = $urandom;
            ld_wmask  = MW'($urandom);
            cyc();
        end
        rst_n = 1'b1;
        idle();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
